// File: rtl/conv_window_sched.sv
// Time-shares one 3x3 convolution PE across every valid window position of a
// square frame. Windows are issued in row-major order and each PE result is streamed out.
module conv_window_sched #(
    parameter int IMG_W  = 12,
    parameter int K      = 3,
    parameter int DW     = 2,
    parameter int RW     = 8,
    parameter int PE_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [IMG_W*IMG_W*DW-1:0] img,
    input  logic [K*K*DW-1:0]         filt,
    output logic                      busy,
    output logic                      done,
    output logic [K*K*DW-1:0]         pe_win,
    output logic [K*K*DW-1:0]         pe_filt,
    output logic                      pe_valid,
    input  logic [RW-1:0]             pe_res,
    output logic [RW-1:0]             out_data,
    output logic [3:0]                out_row,
    output logic [3:0]                out_col,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam int LAST = IMG_W - K;
    localparam int IW   = IMG_W * IMG_W * DW;
    localparam int FW   = K * K * DW;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, DONE} state_t;

    state_t          state_reg;
    logic [IW-1:0]   img_reg;
    logic [3:0]      r_reg;
    logic [3:0]      c_reg;
    logic [2:0]      lat_reg;

    logic [3:0]      r_next;
    logic [3:0]      c_next;
    logic            last_pos;
    logic [IW-1:0]   src_img;
    logic [FW-1:0]   win_next;

    // The window for the first position is cut straight from the input frame,
    // because the frame register is only being loaded on that same edge.
    always_comb begin
        last_pos = (r_reg == 4'(LAST)) && (c_reg == 4'(LAST));
        r_next   = 4'd0;
        c_next   = 4'd0;
        src_img  = img_reg;
        if (state_reg == IDLE) begin
            src_img = img;
        end else if (c_reg != 4'(LAST)) begin
            r_next = r_reg;
            c_next = c_reg + 4'd1;
        end else if (r_reg != 4'(LAST)) begin
            r_next = r_reg + 4'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < K * K; gi++) begin : g_tap
            logic [15:0] pix;
            assign pix = (16'(r_next) + 16'(gi / K)) * 16'(IMG_W)
                       + 16'(c_next) + 16'(gi % K);
            assign win_next[gi*DW +: DW] = src_img[pix*DW +: DW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            img_reg   <= '0;
            r_reg     <= '0;
            c_reg     <= '0;
            lat_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pe_win    <= '0;
            pe_filt   <= '0;
            pe_valid  <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_valid <= 1'b0;
        end else begin
            done     <= 1'b0;
            pe_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        img_reg   <= img;
                        pe_filt   <= filt;
                        pe_win    <= win_next;
                        r_reg     <= '0;
                        c_reg     <= '0;
                        pe_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_reg   <= 3'(PE_LAT - 1);
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (lat_reg == 3'd0) begin
                        out_data  <= pe_res;
                        out_row   <= r_reg;
                        out_col   <= c_reg;
                        out_valid <= 1'b1;
                        state_reg <= OUT;
                    end else begin
                        lat_reg <= lat_reg - 3'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_pos) begin
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            r_reg     <= r_next;
                            c_reg     <= c_next;
                            pe_win    <= win_next;
                            pe_valid  <= 1'b1;
                            state_reg <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: two instances (PE latency 1 and 3),
// each with a behavioural PE, checked against hand-derived per-position results.
module tb_conv_window_sched;
    localparam int IMG_W = 12;
    localparam int K     = 3;
    localparam int DW    = 2;
    localparam int RW    = 8;
    localparam int IW    = IMG_W * IMG_W * DW;
    localparam int FW    = K * K * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, out_ready;
    bit            sel;
    logic [IW-1:0] img;
    logic [FW-1:0] filt;
    int            tests = 0;
    int            fails = 0;

    logic          start1, start3, rdy1, rdy3;
    logic          busy1, done1, pv1, ov1, busy3, done3, pv3, ov3;
    logic [FW-1:0] win1, fl1, win3, fl3;
    logic [RW-1:0] od1, od3, res1, res3;
    logic [3:0]    or1, oc1, or3, oc3;

    assign start1 = start & ~sel;
    assign start3 = start & sel;
    assign rdy1   = sel ? 1'b1 : out_ready;
    assign rdy3   = sel ? out_ready : 1'b1;

    conv_window_sched #(.PE_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .img(img), .filt(filt),
        .busy(busy1), .done(done1), .pe_win(win1), .pe_filt(fl1), .pe_valid(pv1),
        .pe_res(res1), .out_data(od1), .out_row(or1), .out_col(oc1),
        .out_valid(ov1), .out_ready(rdy1));

    conv_window_sched #(.PE_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .img(img), .filt(filt),
        .busy(busy3), .done(done3), .pe_win(win3), .pe_filt(fl3), .pe_valid(pv3),
        .pe_res(res3), .out_data(od3), .out_row(or3), .out_col(oc3),
        .out_valid(ov3), .out_ready(rdy3));

    // Selected-instance view used by the frame driver
    logic          busy, done, pe_valid, out_valid;
    logic [FW-1:0] pe_win, pe_filt;
    logic [RW-1:0] out_data;
    logic [3:0]    out_row, out_col;
    assign busy      = sel ? busy3 : busy1;
    assign done      = sel ? done3 : done1;
    assign pe_valid  = sel ? pv3 : pv1;
    assign out_valid = sel ? ov3 : ov1;
    assign pe_win    = sel ? win3 : win1;
    assign pe_filt   = sel ? fl3 : fl1;
    assign out_data  = sel ? od3 : od1;
    assign out_row   = sel ? or3 : or1;
    assign out_col   = sel ? oc3 : oc1;

    function automatic logic [RW-1:0] dot(input logic [FW-1:0] w, input logic [FW-1:0] f);
        int s = 0;
        for (int t = 0; t < K * K; t++) s += int'(w[t*DW +: DW]) * int'(f[t*DW +: DW]);
        return s[RW-1:0];
    endfunction

    // Behavioural PEs: the result is only meaningful in its valid cycle, 8'hEE otherwise
    logic [RW:0] p1 = '0;
    logic [RW:0] q0 = '0, q1 = '0, q2 = '0;
    always @(posedge clk) begin
        p1 <= {pv1, dot(win1, fl1)};
        q0 <= {pv3, dot(win3, fl3)};
        q1 <= q0;
        q2 <= q1;
    end
    assign res1 = p1[RW] ? p1[RW-1:0] : 8'hEE;
    assign res3 = q2[RW] ? q2[RW-1:0] : 8'hEE;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: pixel (r+c)%4, centre tap 1; mode 1: all 3s; mode 2: pixel r%4, taps (0,0)=1,(2,2)=2
    task automatic set_img(input int mode);
        for (int r = 0; r < IMG_W; r++)
            for (int c = 0; c < IMG_W; c++)
                img[(r*IMG_W+c)*DW +: DW] = (mode == 0) ? 2'((r + c) % 4) :
                                            (mode == 1) ? 2'd3 : 2'(r % 4);
        filt = '0;
        if (mode == 0) filt[(1*K+1)*DW +: DW] = 2'd1;
        if (mode == 1) filt = '1;
        if (mode == 2) begin
            filt[0 +: DW]           = 2'd1;
            filt[(2*K+2)*DW +: DW] = 2'd2;
        end
    endtask

    function automatic int exp_val(input int mode, input int r, input int c);
        if (mode == 0) return (r + c + 2) % 4;
        if (mode == 1) return 81;
        return (r % 4) + 2 * ((r + 2) % 4);
    endfunction

    // Entered at a negedge in an IDLE cycle; returns at the negedge of the DONE
    // cycle, or one cycle after a mid-frame reset.
    task automatic frame(input int mode, input bit rand_ready, input bit pulse,
                         input bit hold, input int rst_at, input int exp_done);
        int n = 0, beats = 0, er = 0, ec = 0, busy_low = 0;
        bit fin = 0, prev_stall = 0, prev_pev = 0;
        logic [RW-1:0] pd = '0;
        logic [3:0] pr = '0, pc = '0;
        logic [FW-1:0] f0 = filt;
        start = 1'b1;
        while (!fin) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("first_issue", pe_valid, 1);
                check("filt_latch", pe_filt, f0);
            end
            if (busy !== 1'b1) busy_low++;
            if (prev_stall) begin
                check("stall_data", out_data, pd);
                check("stall_row", out_row, pr);
                check("stall_col", out_col, pc);
            end
            if (rst_at >= 0 && beats == rst_at && prev_pev) begin
                rst = 1'b1;
                @(negedge clk);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_pev", pe_valid, 0);
                check("abort_ovalid", out_valid, 0);
                check("abort_win", pe_win, 0);
                check("abort_filt", pe_filt, 0);
                check("abort_data", out_data, 0);
                check("abort_rc", {out_row, out_col}, 0);
                rst = 1'b0;
                start = 1'b0;
                $display("[TB] frame aborted by reset at position %0d", beats);
                fin = 1;
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_valid && out_ready) begin
                    check("beat_row", out_row, er);
                    check("beat_col", out_col, ec);
                    check("beat_data", out_data, exp_val(mode, er, ec));
                    $display("[TB] beat r=%0d c=%0d data=%0d", out_row, out_col, out_data);
                    beats++;
                    if (ec == IMG_W - K) begin ec = 0; er++; end else ec++;
                end
                prev_stall = out_valid && !out_ready;
                pd = out_data; pr = out_row; pc = out_col;
                prev_pev = pe_valid;
                start = hold || (pulse && (n == 1 || beats == 37));
                if (done) begin
                    check("beat_count", beats, 100);
                    check("busy_in_frame", busy_low, 0);
                    if (exp_done > 0) check("done_cycle", n, exp_done);
                    $display("[TB] frame done after %0d cycles, %0d beats", n, beats);
                    start = hold || pulse;
                    fin = 1;
                end else if (n > 3000) begin
                    tests++; fails++;
                    $error("FAIL timeout observed=%0d beats expected=100", beats);
                    fin = 1;
                end
            end
        end
    endtask

    task automatic post_idle();
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_pev", pe_valid, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; sel = 1'b0;
        set_img(0);
        repeat (3) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pev", pv1, 0);
        check("rst_ovalid", ov1, 0);
        check("rst_win", win1, 0);
        check("rst_data", od1, 0);
        check("rst_busy3", busy3, 0);
        rst = 1'b0;
        @(negedge clk);

        frame(0, 0, 0, 0, -1, 301);
        post_idle();

        set_img(1);
        frame(1, 0, 0, 0, -1, 301);
        post_idle();

        sel = 1'b1;
        frame(1, 0, 0, 0, -1, 501);
        post_idle();
        sel = 1'b0;

        set_img(0);
        frame(0, 1, 0, 0, -1, 0);
        post_idle();

        set_img(2);
        frame(2, 0, 1, 0, -1, 301);
        post_idle();

        set_img(0);
        frame(0, 0, 0, 0, 55, 0);
        post_idle();
        frame(0, 0, 0, 0, -1, 301);
        post_idle();

        // Back-to-back: start stays high, second image presented during DONE
        set_img(1);
        frame(1, 0, 0, 1, -1, 301);
        set_img(2);
        @(negedge clk);
        check("b2b_idle", busy1, 0);
        frame(2, 0, 0, 0, -1, 301);
        post_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
Sequencer that shares one 3x3 convolution PE across all window positions of a 12x12 image. Software-side logic presents a full frame plus filter and pulses start. The block then walks every valid window position in row-major order. For each position it issues the window to the PE, waits the PE latency, and streams the result out over a valid/ready handshake. It sits between the frame/filter registers and the downstream result collector, in place of a fully unrolled 10x10 PE array.

Parameters:
IMG_W, 12, image width and height in pixels (square)
K, 3, filter width and height (square)
DW, 2, bits per pixel and per filter tap (unsigned)
RW, 8, PE result width in bits
PE_LAT, 1, PE latency in cycles (1..4) from pe_valid to pe_res valid

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a frame; sampled only in IDLE
img  in  IMG_W*IMG_W*DW  frame; pixel (r,c) at bits [(r*IMG_W+c)*DW +: DW]
filt  in  K*K*DW  filter; tap (i,j) at bits [(i*K+j)*DW +: DW]
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last result handshake
pe_win  out  K*K*DW  current window; tap (i,j) = pixel (r+i,c+j), same packing as filt
pe_filt  out  K*K*DW  latched filter
pe_valid  out  1  one-cycle issue strobe to PE
pe_res  in  RW  PE result, valid PE_LAT cycles after pe_valid
out_data  out  RW  result for the current position
out_row  out  4  output row index r, 0..IMG_W-K
out_col  out  4  output column index c, 0..IMG_W-K
out_valid  out  1  result available
out_ready  in  1  downstream accepts

Behaviour:
- Reset: state IDLE. busy, done, pe_valid, out_valid = 0. pe_win, pe_filt, out_data, out_row, out_col = 0. Latched image, filter and counters = 0.
- Reset asserted mid-frame aborts immediately: next cycle is IDLE with reset values, no done pulse, any pending out_valid is dropped.
- IDLE: when start=1, latch img and filt and clear r and c; next state is ISSUE. When start=0, remain in IDLE.
- start while not IDLE (including the DONE cycle) is ignored. img and filt are don't-care after the latch cycle.
- ISSUE (1 cycle): pe_valid=1. pe_win is built from the latched image at (r,c), pe_filt = latched filter. Both are registered so they are stable during ISSUE and hold their value until the next ISSUE. Next state is WAIT.
- WAIT (exactly PE_LAT cycles, down-counter): pe_valid=0. On the last WAIT cycle, capture pe_res into out_data and set out_row=r, out_col=c. Next state is OUT.
- OUT: out_valid=1. out_data, out_row and out_col stay stable while out_ready=0. The handshake completes in a cycle with out_valid & out_ready; out_valid drops the next cycle.
- Advance on handshake:
  - c < IMG_W-K: c+1, go to ISSUE.
  - c = IMG_W-K and r < IMG_W-K: c=0, r+1, go to ISSUE.
  - c = IMG_W-K and r = IMG_W-K: go to DONE.
- DONE (1 cycle): done=1, busy=1. Next state is IDLE.
- Positions per frame: (IMG_W-K+1)^2 = 100. Cycles per position with out_ready held high: 2+PE_LAT.
- Frame length with PE_LAT=1 and out_ready=1: start accepted at edge E0; the first pe_valid is the cycle after E0; done is high 301 cycles after E0.
- No arithmetic is performed here. RW must be at least ceil(log2(K*K*(2^DW-1)^2+1)), which is 7 for the defaults; the PE owns accumulation.

Test Plan:
- Filter centre tap = 1 and all other taps 0, image pixel (r,c) = (r+c) mod 4, out_ready=1, PE_LAT=1 -> 100 beats in row-major order. Beat (r,c) has out_data = (r+c+2) mod 4. done is 301 cycles after start. No gaps other than ISSUE/WAIT.
- All pixels 3, all taps 3 -> every out_data = 81 and busy stays high for the whole frame. Repeat with PE_LAT=3 -> 5 cycles per beat, same data.
- Random out_ready (about 50% duty) -> out_data, out_row and out_col are stable while stalled. There are exactly 100 handshakes and no duplicated or skipped (r,c).
- Pulse start at positions 0, 37 and in the DONE cycle -> ignored: frame contents and beat count unchanged, one done only.
- Assert rst during WAIT of position 55 -> next cycle all outputs are at reset values with no done. A new start then produces a full 100-beat frame from (0,0).
- Back-to-back frames, with start held high continuously -> the second frame begins the cycle after returning to IDLE. Its results use the second image/filter latched at that point.
